sonar_responder: RTL
====================

# sonar_responder

Synthesizable emulator of an HC-SR04 ultrasonic sensor: the responder end of the trigger/echo interface driven by the trena measurement block. It accepts a trigger pulse, waits a fixed transducer delay, then drives an echo pulse whose width encodes a programmed distance in centimetres. It is used in loopback on the FPGA board in place of the physical sensor, and as a self-checking stimulus source in benches.

## Interface
- `T_TRIG_MIN`, default 500: minimum valid trigger high time in clock cycles (10 µs at 50 MHz).
- `T_ATRASO`, default 20000: delay from trigger fall to echo rise in cycles (400 µs).
- `CICLOS_POR_CM`, default 2941: echo cycles per centimetre (58.82 µs/cm).
- `T_TIMEOUT`, default 1900000: echo width when no object is present (38 ms).
- `T_HOLDOFF`, default 500000: dead time after echo fall before a new trigger is accepted (10 ms).

Ports:
- `clock` input 1: system clock, 50 MHz. Single clock domain.
- `reset` input 1: synchronous, active-low.
- `trigger` input 1: asynchronous trigger from the initiator.
- `distancia` input 9: programmed distance in cm, unsigned.
- `sem_objeto` input 1: 1 means no echo target, so the echo uses `T_TIMEOUT`.
- `echo` output 1: echo pulse, registered.
- `ocupado` output 1: 1 in any state other than OCIOSO.
- `erro_trigger` output 1: single-cycle pulse when a trigger pulse is too short.
- `db_estado` output 4: current state encoding, for debug and hex display.

## Operation
- `trigger` passes through a 2-flop synchronizer. All logic uses the synchronized signal `trig_s` and its previous value.
- Single down-counter `cont`, 21 bits wide. The maximum load is 1900000, which is less than 2^21.
- Distance clamping applied at latch:
  - `distancia` < 2 → 2.
  - `distancia` > 400 → 400.
- Echo width (`largura`):
  - `sem_objeto` = 0: `largura` = `dist_clamp` × `CICLOS_POR_CM`. This is at most 1176400 and is computed into 21 bits with no truncation.
  - `sem_objeto` = 1: `largura` = `T_TIMEOUT`.
- FSM states and encodings:
  - OCIOSO = 0. `echo` = 0. On a `trig_s` rising edge, load `cont` = 1 and go to TRIG_ALTO.
  - TRIG_ALTO = 1. While `trig_s` = 1, increment `cont`, saturating at `T_TRIG_MIN`. On `trig_s` falling:
    - if `cont` ≥ `T_TRIG_MIN`: latch `distancia` and `sem_objeto`, load `cont` = `T_ATRASO`, go to ATRASO;
    - otherwise: pulse `erro_trigger` for 1 cycle and go to OCIOSO.
  - ATRASO = 2. Decrement `cont`. When `cont` = 1, set `echo` = 1, load `cont` = `largura`, go to ECO.
  - ECO = 3. `echo` = 1. Decrement `cont`. When `cont` = 1, set `echo` = 0, load `T_HOLDOFF`, go to ESPERA.
  - ESPERA = 4. `echo` = 0. Decrement `cont`. When `cont` = 1, go to OCIOSO.
- Triggers are ignored in ATRASO, ECO and ESPERA. A trigger still high on entry to OCIOSO does not start a cycle; a fresh rising edge is required.
- Changes to `distancia` and `sem_objeto` after the latch do not affect the pulse in progress.
- Reset (`reset` = 0 at a clock edge), in any state including mid-echo:
  - state → OCIOSO;
  - `echo`, `erro_trigger`, `ocupado` → 0;
  - `cont` → 0;
  - synchronizer flops → 0;
  - `db_estado` → 0.

## Timing
- Trigger edge to FSM: 2 cycles of synchronizer latency, plus 1 cycle to detect the edge.
- Trigger acceptance: valid if `trig_s` is high for ≥ `T_TRIG_MIN` cycles. A pulse of exactly `T_TRIG_MIN` cycles is accepted; `T_TRIG_MIN` − 1 cycles is rejected.
- Echo rise: exactly `T_ATRASO` cycles after the edge on which the FSM enters ATRASO.
- Echo width: exactly `largura` cycles, glitch-free.
- `erro_trigger`: asserted the cycle after the `trig_s` fall is detected, for exactly 1 cycle.
- `ocupado`: rises with the transition into TRIG_ALTO and falls on the transition into OCIOSO.
- Minimum trigger-to-trigger period for a full response: `T_ATRASO` + `largura` + `T_HOLDOFF` + trigger time.

## Test plan
1. Reset held for 100 cycles, then released → `echo` = 0, `ocupado` = 0, `db_estado` = 0; no activity for 10000 cycles.
2. `distancia` = 100, 10 µs trigger (500 cycles) → `echo` rises 400 µs ± 3 cycles after trigger fall; width = 294100 cycles (5.882 ms); ESPERA lasts 500000 cycles, then OCIOSO.
3. Trigger of 499 cycles → `erro_trigger` pulses for 1 cycle, `echo` stays 0, state returns to OCIOSO. A following 500-cycle trigger → normal echo.
4. Boundaries:
   - `sem_objeto` = 1 → echo width 1900000 cycles;
   - `distancia` = 0 → width 5882;
   - `distancia` = 511 → width 1176400.
5. Second trigger during ECO, and `distancia` changed from 100 to 50 mid-echo → both ignored; width stays 294100 and only one echo is produced.
6. `reset` asserted 1000 cycles into ECO → `echo` = 0 on the next edge, state OCIOSO; a new trigger after release → full correct echo.

Source files
------------

// File: rtl/sonar_responder.sv
// sonar_responder: HC-SR04 ultrasonic sensor emulator (responder side).
// Accepts a trigger pulse and waits a fixed transducer delay. It then drives
// an echo pulse whose width encodes a programmed distance in centimetres, or
// a fixed timeout width when no object is present. After the echo it waits a
// hold-off time before it accepts another trigger.

module sonar_responder #(
  parameter int unsigned T_TRIG_MIN    = 500,      // min trigger high time, cycles
  parameter int unsigned T_ATRASO      = 20000,    // trigger fall -> echo rise
  parameter int unsigned CICLOS_POR_CM = 2941,     // echo cycles per centimetre
  parameter int unsigned T_TIMEOUT     = 1900000,  // echo width with no object
  parameter int unsigned T_HOLDOFF     = 500000    // dead time after echo fall
) (
  input  logic       clock,
  input  logic       reset,         // synchronous, active-low
  input  logic       trigger,       // asynchronous to clock
  input  logic [8:0] distancia,     // programmed distance, cm
  input  logic       sem_objeto,    // 1: no target, echo uses T_TIMEOUT
  output logic       echo,
  output logic       ocupado,
  output logic       erro_trigger,
  output logic [3:0] db_estado
);

  // One 21-bit down-counter covers every interval. The longest load is
  // T_TIMEOUT = 1900000, which is below 2^21.
  localparam int CW = 21;

  localparam logic [CW-1:0] TRIG_MIN_C = CW'(T_TRIG_MIN);
  localparam logic [CW-1:0] ATRASO_C   = CW'(T_ATRASO);
  localparam logic [CW-1:0] CPC_C      = CW'(CICLOS_POR_CM);
  localparam logic [CW-1:0] TIMEOUT_C  = CW'(T_TIMEOUT);
  localparam logic [CW-1:0] HOLDOFF_C  = CW'(T_HOLDOFF);
  localparam logic [CW-1:0] ONE_C      = CW'(1);

  localparam logic [8:0] DIST_MIN = 9'd2;
  localparam logic [8:0] DIST_MAX = 9'd400;

  // These encodings appear directly on db_estado.
  typedef enum logic [3:0] {
    OCIOSO    = 4'd0,
    TRIG_ALTO = 4'd1,
    ATRASO    = 4'd2,
    ECO       = 4'd3,
    ESPERA    = 4'd4
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cont_q, cont_d;
  logic            echo_q, echo_d;
  logic            erro_q, erro_d;

  // Trigger synchronizer and edge-detect history.
  logic            sync1_q;
  logic            trig_s_q;
  logic            trig_prev_q;
  logic            trig_rise;

  // Measurement parameters, latched when a trigger is accepted.
  logic            latch_en;
  logic [8:0]      dist_clamp;
  logic [8:0]      dist_clamp_q;
  logic            sem_q;
  logic [CW-1:0]   largura;

  // Two-flop synchronizer for the asynchronous trigger, plus one history flop
  // for edge detection.
  // NOTE: every clocked process uses non-blocking '<=' so that all flops
  // sample their old values on the same edge. Blocking '=' here would
  // collapse the synchronizer chain into a single flop.
  always_ff @(posedge clock) begin
    if (!reset) begin
      sync1_q     <= 1'b0;
      trig_s_q    <= 1'b0;
      trig_prev_q <= 1'b0;
    end else begin
      sync1_q     <= trigger;
      trig_s_q    <= sync1_q;
      trig_prev_q <= trig_s_q;
    end
  end

  // A cycle starts only on a fresh rising edge. A trigger that is still high
  // when the FSM returns to OCIOSO is ignored.
  assign trig_rise = trig_s_q & ~trig_prev_q;

  // Clamp the programmed distance to the sensor's 2..400 cm range.
  assign dist_clamp = (distancia < DIST_MIN) ? DIST_MIN :
                      (distancia > DIST_MAX) ? DIST_MAX : distancia;

  // Capture the distance and target flag at trigger acceptance. Later input
  // changes do not affect the pulse in progress.
  // NOTE: these are datapath registers with no reset. They are always written
  // at acceptance, before the FSM reads them, so a reset would only add
  // fan-out on the reset net.
  always_ff @(posedge clock) begin
    if (latch_en) begin
      dist_clamp_q <= dist_clamp;
      sem_q        <= sem_objeto;
    end
  end

  // Echo width from the latched values. The largest product is
  // 400 * 2941 = 1176400, so it fits in CW bits without truncation.
  assign largura = sem_q ? TIMEOUT_C : (CW'(dist_clamp_q) * CPC_C);

  // FSM state, counter and registered outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= OCIOSO;
      cont_q  <= '0;
      echo_q  <= 1'b0;
      erro_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cont_q  <= cont_d;
      echo_q  <= echo_d;
      erro_q  <= erro_d;
    end
  end

  // Next-state, counter and output decode.
  // NOTE: every signal driven here gets a default first. A path that leaves
  // a signal unassigned would infer a latch.
  always_comb begin
    state_d  = state_q;
    cont_d   = cont_q;
    echo_d   = echo_q;
    erro_d   = 1'b0;
    latch_en = 1'b0;

    case (state_q)
      OCIOSO: begin
        echo_d = 1'b0;
        if (trig_rise) begin
          // The edge-detect cycle already counts as one high cycle.
          cont_d  = ONE_C;
          state_d = TRIG_ALTO;
        end
      end

      TRIG_ALTO: begin
        if (trig_s_q) begin
          // Count high time, saturating at the acceptance threshold.
          if (cont_q < TRIG_MIN_C) begin
            cont_d = cont_q + ONE_C;
          end
        end else if (cont_q >= TRIG_MIN_C) begin
          latch_en = 1'b1;
          cont_d   = ATRASO_C;
          state_d  = ATRASO;
        end else begin
          erro_d  = 1'b1;
          state_d = OCIOSO;
        end
      end

      ATRASO: begin
        // Transducer delay. Echo rises T_ATRASO cycles after entry.
        if (cont_q <= ONE_C) begin
          echo_d  = 1'b1;
          cont_d  = largura;
          state_d = ECO;
        end else begin
          cont_d = cont_q - ONE_C;
        end
      end

      ECO: begin
        echo_d = 1'b1;
        if (cont_q <= ONE_C) begin
          echo_d  = 1'b0;
          cont_d  = HOLDOFF_C;
          state_d = ESPERA;
        end else begin
          cont_d = cont_q - ONE_C;
        end
      end

      ESPERA: begin
        echo_d = 1'b0;
        if (cont_q <= ONE_C) begin
          state_d = OCIOSO;
        end else begin
          cont_d = cont_q - ONE_C;
        end
      end

      default: begin
        echo_d  = 1'b0;
        state_d = OCIOSO;
      end
    endcase
  end

  assign echo         = echo_q;
  assign erro_trigger = erro_q;
  assign ocupado      = (state_q != OCIOSO);
  assign db_estado    = state_q;

endmodule
